// File: rtl/ahb_to_apb_bridge_mslv.sv
// rtl/ahb_to_apb_bridge_mslv.sv - AHB-Lite slave to multi-slave APB3 master bridge
// Optional PREADY-low timeout in ACCESS is compiled in with AHB_APB_TIMEOUT_EN.
module ahb_to_apb_bridge_mslv #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             HSEL,
  input  logic                             HWRITE,
  input  logic                             HREADY_IN,
  input  logic [1:0]                       HTRANS,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HRESP,
  output logic                             HREADY_OUT,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [IDX_W:0] NUM_SLAVES_W = (IDX_W + 1)'(NUM_SLAVES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic                    hresp_q, hresp_d;
  logic                    hready_q, hready_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;

  logic [IDX_W-1:0]        haddr_idx;
  logic                    accept;
  logic                    idx_in_range;
  logic                    sel_pready;
  logic                    sel_pslverr;
  logic [DATA_WIDTH-1:0]   sel_prdata;
  logic [NUM_SLAVES-1:0]   idx_onehot;
  logic                    tmo_hit;
  logic                    unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // A single-slave build has no index bits in the address at all.
  generate
    if (NUM_SLAVES > 1) begin : g_idx
      assign haddr_idx = HADDR[SLAVE_ADDR_BITS +: IDX_W];
    end else begin : g_no_idx
      assign haddr_idx = '0;
    end
  endgenerate

  assign accept = HSEL & HTRANS[1] & HREADY_IN &
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign idx_in_range = ({1'b0, idx_q} < NUM_SLAVES_W);

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    idx_onehot  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_pready    = PREADY[i];
        sel_pslverr   = PSLVERR[i];
        sel_prdata    = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        idx_onehot[i] = 1'b1;
      end
    end
  end

`ifdef AHB_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ST_ACCESS) && !sel_pready) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  // Fires on the edge that closes the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  assign tmo_hit = (state_q == ST_ACCESS) && !sel_pready &&
                   (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [31:0] unused_tmo_cfg;

  assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_LATCH;
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          idx_d    = haddr_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (pwrite_q) begin
          pwdata_d = HWDATA;
        end
        state_d = idx_in_range ? ST_SETUP : ST_ERR1;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (tmo_hit) begin
          state_d = ST_ERR1;
        end else if (sel_pready) begin
          if (sel_pslverr) begin
            state_d = ST_ERR1;
          end else begin
            if (!pwrite_q) begin
              hrdata_d = sel_prdata;
            end
            state_d = ST_DONE;
          end
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      // Any transfer offered here is cancelled by the master, so it is dropped.
      ST_ERR2: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every one of them is a flop.
  always_comb begin
    hready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d   = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    penable_d = (state_d == ST_ACCESS);
    psel_d    = '0;
    if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
      psel_d = idx_onehot;
    end
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      hresp_q   <= 1'b0;
      hready_q  <= 1'b1;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      hresp_q   <= hresp_d;
      hready_q  <= hready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign HRDATA     = hrdata_q;
  assign HRESP      = hresp_q;
  assign HREADY_OUT = hready_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge_mslv.sv
// tb/tb_ahb_to_apb_bridge_mslv.sv - self-checking bench for ahb_to_apb_bridge_mslv
// Honours AHB_APB_TIMEOUT_EN to pick the stalled-slave expectation.
`timescale 1ns/1ps
module tb_ahb_to_apb_bridge_mslv;

  localparam int TMO = 16;
`ifdef AHB_APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         hsel, hsel3, hwrite, hready_in;
  logic [1:0]   htrans;
  logic [31:0]  haddr, hwdata;
  logic [31:0]  hrdata, hrdata3;
  logic         hresp, hresp3, hready_out, hready_out3;
  logic [3:0]   psel;
  logic [2:0]   psel3;
  logic         penable, penable3, pwrite, pwrite3;
  logic [31:0]  paddr, paddr3, pwdata, pwdata3;
  logic [127:0] prdata;
  logic [95:0]  prdata3;
  logic [3:0]   pready, pslverr;
  logic [2:0]   pready3, pslverr3;

  int           total = 0;
  int           bad = 0;
  logic [31:0]  exp_hrdata;
  logic [31:0]  ref_mem [logic [31:0]];

  assign prdata3  = {3{32'h0BAD_0BAD}};
  assign pready3  = 3'b111;
  assign pslverr3 = 3'b000;

  ahb_to_apb_bridge_mslv #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(TMO)) u_dut (
    .HCLK(clk), .HRESETn(rst), .HSEL(hsel), .HWRITE(hwrite), .HREADY_IN(hready_in),
    .HTRANS(htrans), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata), .HRESP(hresp),
    .HREADY_OUT(hready_out), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  ahb_to_apb_bridge_mslv #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(TMO)) u_dut3 (
    .HCLK(clk), .HRESETn(rst), .HSEL(hsel3), .HWRITE(hwrite), .HREADY_IN(hready_in),
    .HTRANS(htrans), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata3), .HRESP(hresp3),
    .HREADY_OUT(hready_out3), .PSEL(psel3), .PENABLE(penable3), .PWRITE(pwrite3),
    .PADDR(paddr3), .PWDATA(pwdata3), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] periph_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hC3C3_5A5A;
  endfunction

  // One AHB transfer to the 4-slave bridge, with a bench-side APB slave that
  // stalls nwait cycles and then answers. Called and returning at a negedge.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int nwait, input bit slverr, input bit poke_err2);
    int          s, exp_acc, exp_waits, waits, psel_n, pen_n, hresp_n;
    bit          tmo, exp_err, done, psel_ok, rdy;
    logic [3:0]  oh;
    logic [31:0] rd_val;
    s         = int'(addr[13:12]);
    oh        = 4'b0001 << s;
    tmo       = TMO_EN && (nwait >= TMO);
    exp_acc   = tmo ? TMO : nwait + 1;
    exp_err   = slverr || tmo;
    exp_waits = 2 + exp_acc + (exp_err ? 1 : 0);
    rd_val    = periph_rd(addr);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hready_in = 1'b1;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    waits = 0; psel_n = 0; pen_n = 0; hresp_n = 0; done = 1'b0; psel_ok = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      if (hready_out === 1'b1) begin
        done = 1'b1;
      end else begin
        waits++;
        if (hresp === 1'b1) hresp_n++;
        if (psel !== 4'b0000) begin
          psel_n++;
          if (psel !== oh) psel_ok = 1'b0;
          if (psel_n == 1) begin
            check("setup_penable", penable, 0);
            check("setup_paddr", paddr, addr);
            check("setup_pwrite", pwrite, wr);
            if (wr) check("setup_pwdata", pwdata, wdata);
          end
          if (penable === 1'b1) begin
            pen_n++;
            rdy = (pen_n > nwait);
            pready = 4'b1111; pslverr = 4'b1111; prdata = {4{~rd_val}};
            pready[s]  = rdy;
            pslverr[s] = rdy ? slverr : 1'($urandom_range(0, 1));
            prdata[s*32 +: 32] = rd_val;
            if (rdy && wr && !slverr) ref_mem[addr] = wdata;
          end
        end
        @(negedge clk);
      end
    end
    pready = 4'b0000; pslverr = 4'b0000;
    check("xfer_completed", done, 1);
    check("wait_states", waits, exp_waits);
    check("psel_cycles", psel_n, 1 + exp_acc);
    check("penable_cycles", pen_n, exp_acc);
    check("psel_onehot", psel_ok, 1);
    check("err1_hresp_cycles", hresp_n, exp_err ? 1 : 0);
    check("ready_hresp", hresp, exp_err);
    if (!wr && !exp_err) exp_hrdata = rd_val;
    check("hrdata", hrdata, exp_hrdata);
    if (exp_err) begin
      if (poke_err2) begin
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0000_0000;
      end
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00;
      check("post_err_hresp", hresp, 0);
      check("post_err_ready", hready_out, 1);
      check("post_err_psel", psel, 0);
    end
  endtask

  int          rn_wait;
  bit          rn_wr, rn_err, rn_poke;
  logic [31:0] rn_addr, rn_data;

  initial begin
    rst = 1'b1; hsel = 1'b0; hsel3 = 1'b0; hwrite = 1'b0; hready_in = 1'b1;
    htrans = 2'b00; haddr = '0; hwdata = '0; pready = '0; pslverr = '0; prdata = '0;
    exp_hrdata = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_hresp", hresp, 0);
    check("rst_hready", hready_out, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hready", hready_out, 1);

    // Zero-wait write to slave 1, then stalled read from slave 2.
    do_xfer(1'b1, 32'h0000_1004, 32'hBEEF_BEEF, 0, 1'b0, 1'b0);
    ref_mem[32'h0000_2008] = 32'hCAFE_F00D;
    do_xfer(1'b0, 32'h0000_2008, 32'h0, 3, 1'b0, 1'b0);
    check("plan_read_data", hrdata, 32'hCAFE_F00D);

    // PSLVERR on slave 3, with a transfer offered during ERR2, then an OKAY read.
    do_xfer(1'b1, 32'h0000_3000, 32'h5555_AAAA, 0, 1'b1, 1'b1);
    do_xfer(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, 1'b0);

    // Decode miss on the 3-slave bridge.
    hsel3 = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0000_3000; hready_in = 1'b1;
    @(negedge clk);
    hsel3 = 1'b0; htrans = 2'b00;
    check("miss_latch_ready", hready_out3, 0);
    check("miss_latch_hresp", hresp3, 0);
    @(negedge clk);
    check("miss_err1_ready", hready_out3, 0);
    check("miss_err1_hresp", hresp3, 1);
    check("miss_err1_psel", psel3, 0);
    @(negedge clk);
    check("miss_err2_ready", hready_out3, 1);
    check("miss_err2_hresp", hresp3, 1);
    check("miss_err2_psel", psel3, 0);
    check("miss_err2_penable", penable3, 0);
    @(negedge clk);
    check("miss_idle_hresp", hresp3, 0);
    check("miss_idle_ready", hready_out3, 1);

    // Reset asserted while the slave holds the bridge in ACCESS.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0000_0000; pready = 4'b0000;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    for (int c = 0; c < 10 && penable !== 1'b1; c++) @(negedge clk);
    check("rst_mid_in_access", penable, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_psel", psel, 0);
    check("rst_mid_penable", penable, 0);
    check("rst_mid_hready", hready_out, 1);
    check("rst_mid_hresp", hresp, 0);
    exp_hrdata = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 1, 1'b0, 1'b0);

    // Slave 0 stalls for a long time.
`ifdef AHB_APB_TIMEOUT_EN
    do_xfer(1'b0, 32'h0000_0040, 32'h0, 30, 1'b0, 1'b0);
`else
    do_xfer(1'b0, 32'h0000_0040, 32'h0, 110, 1'b0, 1'b0);
`endif

    // Randomised back-to-back traffic with occasional non-accepting cycles.
    for (int n = 0; n < 40; n++) begin
      rn_wr   = 1'($urandom_range(0, 1));
      rn_addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 2) |
                (32'($urandom_range(0, 1)) << 20);
      rn_data = $urandom;
      rn_wait = $urandom_range(0, 4);
      rn_err  = ($urandom_range(0, 4) == 0);
      rn_poke = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        hready_in = 1'b1;
        case ($urandom_range(0, 3))
          0:       begin hsel = 1'b0; htrans = 2'b10; end
          1:       begin hsel = 1'b1; htrans = 2'b00; end
          2:       begin hsel = 1'b1; htrans = 2'b01; end
          default: begin hsel = 1'b1; htrans = 2'b10; hready_in = 1'b0; end
        endcase
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hready_in = 1'b1;
        check("no_accept_ready", hready_out, 1);
        check("no_accept_psel", psel, 0);
      end
      do_xfer(rn_wr, rn_addr, rn_data, rn_wait, rn_err, rn_poke);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
